// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit between decode and EX.
// Tracks the last FWD_DEPTH issued destinations; youngest matching producer wins.
module fwd_hazard_unit #(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1,
  parameter int SELW      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ins_valid,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              rt_used,
  input  logic [REG_AW-1:0] rd,
  input  logic              wr_en,
  input  logic              is_load,
  input  logic              is_jump,
  output logic              stall,
  output logic              ex_valid,
  output logic [SELW-1:0]   fwd_sel_a,
  output logic [SELW-1:0]   fwd_sel_b,
  output logic [REG_AW-1:0] rw_ex
);

  // Index 0 holds S[1], the most recently issued instruction.
  logic [FWD_DEPTH-1:0] v_q;
  logic [FWD_DEPTH-1:0] ld_q;
  logic [REG_AW-1:0]    dst_q [FWD_DEPTH];
  logic [1:0]           flush_cnt_q;

  logic                 squash;
  logic                 accept;
  logic                 load_hit;
  logic [FWD_DEPTH-1:0] hit_a;
  logic [FWD_DEPTH-1:0] hit_b;
  logic [SELW-1:0]      sel_a_d;
  logic [SELW-1:0]      sel_b_d;

  assign squash = (flush_cnt_q != 2'd0);
  assign accept = ins_valid & ~stall & ~squash;

  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      hit_a[k] = v_q[k] && (dst_q[k] == rs) && (rs != '0);
      hit_b[k] = rt_used && v_q[k] && (dst_q[k] == rt) && (rt != '0);
    end
  end

  // Only loads still inside the load latency window block issue.
  always_comb begin
    load_hit = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      load_hit = load_hit | (ld_q[k] & (hit_a[k] | hit_b[k]));
    end
    stall = reset & ins_valid & ~squash & load_hit;
  end

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    sel_a_d = '0;
    sel_b_d = '0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (hit_a[k]) sel_a_d = SELW'(k + 1);
      if (hit_b[k]) sel_b_d = SELW'(k + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q         <= '0;
      ld_q        <= '0;
      for (int k = 0; k < FWD_DEPTH; k++) dst_q[k] <= '0;
      flush_cnt_q <= 2'd0;
      ex_valid    <= 1'b0;
      fwd_sel_a   <= '0;
      fwd_sel_b   <= '0;
      rw_ex       <= '0;
    end else begin
      for (int k = FWD_DEPTH - 1; k > 0; k--) begin
        v_q[k]   <= v_q[k-1];
        ld_q[k]  <= ld_q[k-1];
        dst_q[k] <= dst_q[k-1];
      end
      v_q[0]   <= accept & wr_en & (rd != '0);
      ld_q[0]  <= accept & is_load;
      dst_q[0] <= rd;

      ex_valid  <= accept;
      fwd_sel_a <= accept ? sel_a_d : '0;
      fwd_sel_b <= accept ? sel_b_d : '0;
      rw_ex     <= (accept & wr_en) ? rd : '0;

      if (accept && is_jump) begin
        flush_cnt_q <= 2'(FLUSH_CYC);
      end else if (squash && ins_valid) begin
        flush_cnt_q <= flush_cnt_q - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed test-plan scenarios then random traffic,
// all checked against a queue-based history model.
module tb_fwd_hazard_unit;

  localparam int Depth = 3;
  localparam int LoadLat = 1;
  localparam int FlushCyc = 1;

  logic       clk = 1'b0;
  logic       reset, ins_valid, rt_used, wr_en, is_load, is_jump;
  logic [4:0] rs, rt, rd;
  logic       stall, ex_valid;
  logic [2:0] fwd_sel_a, fwd_sel_b;
  logic [4:0] rw_ex;

  fwd_hazard_unit #(
    .REG_AW(5), .FWD_DEPTH(Depth), .LOAD_LAT(LoadLat), .FLUSH_CYC(FlushCyc), .SELW(3)
  ) dut (
    .clk(clk), .reset(reset), .ins_valid(ins_valid), .rs(rs), .rt(rt), .rt_used(rt_used),
    .rd(rd), .wr_en(wr_en), .is_load(is_load), .is_jump(is_jump), .stall(stall),
    .ex_valid(ex_valid), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .rw_ex(rw_ex)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: history of issued producers, youngest first.
  typedef struct { bit v; int dst; bit ld; } ent_t;
  ent_t hist[$];
  int   flush_left;
  bit   m_stall, m_accept;
  int   m_sel_a, m_sel_b;
  int   e_ex_valid, e_sel_a, e_sel_b, e_rw_ex;

  function automatic bit producer_hits(int k, int r);
    return hist[k].v && hist[k].dst == r && r != 0;
  endfunction

  task automatic model_clear();
    ent_t b;
    b = '{v: 0, dst: 0, ld: 0};
    hist.delete();
    for (int i = 0; i < Depth; i++) hist.push_back(b);
    flush_left = 0;
    e_ex_valid = 0; e_sel_a = 0; e_sel_b = 0; e_rw_ex = 0;
  endtask

  task automatic model_eval();
    bit squash, dep;
    squash = flush_left != 0;
    dep = 0;
    for (int k = 0; k < LoadLat; k++)
      if (hist[k].ld && (producer_hits(k, int'(rs)) || (rt_used && producer_hits(k, int'(rt)))))
        dep = 1;
    m_stall  = reset && ins_valid && !squash && dep;
    m_accept = ins_valid && !m_stall && !squash;
    m_sel_a = 0;
    m_sel_b = 0;
    for (int k = 0; k < Depth; k++) begin
      if (m_sel_a == 0 && producer_hits(k, int'(rs))) m_sel_a = k + 1;
      if (m_sel_b == 0 && rt_used && producer_hits(k, int'(rt))) m_sel_b = k + 1;
    end
  endtask

  task automatic model_commit();
    ent_t n;
    if (!reset) begin
      model_clear();
      return;
    end
    e_ex_valid = m_accept;
    e_sel_a    = m_accept ? m_sel_a : 0;
    e_sel_b    = m_accept ? m_sel_b : 0;
    e_rw_ex    = (m_accept && wr_en) ? int'(rd) : 0;
    n.v   = m_accept && wr_en && rd != 0;
    n.dst = int'(rd);
    n.ld  = m_accept && is_load;
    hist.push_front(n);
    void'(hist.pop_back());
    if (m_accept && is_jump) flush_left = FlushCyc;
    else if (flush_left != 0 && ins_valid) flush_left--;
  endtask

  // One decode cycle: drive at negedge, check stall, clock, check registered outputs.
  task automatic step(input logic rst_n, input logic v, input logic [4:0] a, input logic [4:0] b,
                      input logic bu, input logic [4:0] d, input logic we, input logic ld,
                      input logic jp, output bit st);
    reset = rst_n; ins_valid = v; rs = a; rt = b; rt_used = bu;
    rd = d; wr_en = we; is_load = ld; is_jump = jp;
    #1;
    model_eval();
    check_eq("stall", int'(stall), int'(m_stall));
    st = m_stall;
    @(posedge clk);
    model_commit();
    @(negedge clk);
    check_eq("ex_valid", int'(ex_valid), e_ex_valid);
    check_eq("fwd_sel_a", int'(fwd_sel_a), e_sel_a);
    check_eq("fwd_sel_b", int'(fwd_sel_b), e_sel_b);
    check_eq("rw_ex", int'(rw_ex), e_rw_ex);
  endtask

  bit st;
  logic r_rst, r_v, r_bu, r_we, r_ld, r_jp;
  logic [4:0] r_a, r_b, r_d;

  initial begin
    model_clear();
    @(negedge clk);
    step(0, 1, 5'd3, 5'd0, 0, 5'd3, 1, 0, 0, st);
    check_eq("reset_stall", int'(stall), 0);

    // Back-to-back dependency.
    step(1, 1, 5'd0, 5'd0, 0, 5'd3, 1, 0, 0, st);
    step(1, 1, 5'd3, 5'd0, 0, 5'd9, 1, 0, 0, st);
    check_eq("b2b_sel_a", int'(fwd_sel_a), 1);
    check_eq("b2b_nostall", int'(st), 0);

    // Distance 3, then out of range.
    step(1, 1, 5'd0, 5'd0, 0, 5'd5, 1, 0, 0, st);
    step(1, 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, st);
    step(1, 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, st);
    step(1, 1, 5'd0, 5'd5, 1, 5'd0, 0, 0, 0, st);
    check_eq("dist3_sel_b", int'(fwd_sel_b), 3);
    step(1, 1, 5'd0, 5'd0, 0, 5'd5, 1, 0, 0, st);
    for (int i = 0; i < 3; i++) step(1, 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, st);
    step(1, 1, 5'd0, 5'd5, 1, 5'd0, 0, 0, 0, st);
    check_eq("dist4_sel_b", int'(fwd_sel_b), 0);

    // Load-use: one stall, one bubble, then forward from slot 2.
    step(1, 1, 5'd0, 5'd0, 0, 5'd4, 1, 1, 0, st);
    step(1, 1, 5'd4, 5'd0, 0, 5'd8, 1, 0, 0, st);
    check_eq("lu_stall", int'(st), 1);
    check_eq("lu_bubble", int'(ex_valid), 0);
    step(1, 1, 5'd4, 5'd0, 0, 5'd8, 1, 0, 0, st);
    check_eq("lu_restall", int'(st), 0);
    check_eq("lu_sel_a", int'(fwd_sel_a), 2);
    step(1, 1, 5'd0, 5'd0, 0, 5'd4, 1, 1, 0, st);
    step(1, 1, 5'd0, 5'd4, 0, 5'd0, 0, 0, 0, st);
    check_eq("lu_imm_nostall", int'(st), 0);

    // Youngest wins; register 0 never forwards.
    step(1, 1, 5'd0, 5'd0, 0, 5'd7, 1, 0, 0, st);
    step(1, 1, 5'd0, 5'd0, 0, 5'd7, 1, 0, 0, st);
    step(1, 1, 5'd7, 5'd0, 0, 5'd0, 0, 0, 0, st);
    check_eq("youngest_sel_a", int'(fwd_sel_a), 1);
    step(1, 1, 5'd0, 5'd0, 0, 5'd0, 1, 1, 0, st);
    step(1, 1, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, st);
    check_eq("r0_nostall", int'(st), 0);
    check_eq("r0_sel_a", int'(fwd_sel_a), 0);

    // Jump shadow, with a load right before the jump.
    step(1, 1, 5'd0, 5'd0, 0, 5'd6, 1, 1, 0, st);
    step(1, 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, st);
    step(1, 1, 5'd6, 5'd0, 0, 5'd6, 1, 0, 0, st);
    check_eq("jump_squash_v", int'(ex_valid), 0);
    check_eq("jump_squash_rw", int'(rw_ex), 0);
    step(1, 1, 5'd0, 5'd0, 0, 5'd2, 1, 0, 0, st);
    check_eq("jump_after_v", int'(ex_valid), 1);

    // Reset in the middle of a stall.
    step(1, 1, 5'd0, 5'd0, 0, 5'd4, 1, 1, 0, st);
    step(1, 1, 5'd4, 5'd0, 0, 5'd0, 0, 0, 0, st);
    check_eq("rst_pre_stall", int'(st), 1);
    step(0, 1, 5'd4, 5'd0, 0, 5'd0, 0, 0, 0, st);
    check_eq("rst_ex_valid", int'(ex_valid), 0);
    step(1, 1, 5'd4, 5'd0, 0, 5'd0, 0, 0, 0, st);
    check_eq("rst_after_sel", int'(fwd_sel_a), 0);

    // Random traffic; a stalled instruction is re-presented unchanged.
    r_a = '0; r_b = '0; r_d = '0; r_bu = 0; r_we = 0; r_ld = 0; r_jp = 0; r_v = 0;
    st = 0;
    for (int i = 0; i < 600; i++) begin
      r_rst = ($urandom_range(0, 39) != 0);
      if (!st) begin
        r_v  = ($urandom_range(0, 9) != 0);
        r_a  = 5'($urandom_range(0, 7));
        r_b  = 5'($urandom_range(0, 7));
        r_d  = 5'($urandom_range(0, 7));
        r_bu = 1'($urandom_range(0, 1));
        r_we = ($urandom_range(0, 3) != 0);
        r_ld = ($urandom_range(0, 2) == 0);
        r_jp = ($urandom_range(0, 7) == 0);
      end
      step(r_rst, r_v, r_a, r_b, r_bu, r_d, r_we, r_ld, r_jp, st);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
